// File: rtl/ps2_pkg.sv
// Shared constants, FSM state encoding and event packing for the PS/2 key sequencer.
package ps2_pkg;

   localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
   localparam logic [7:0] PS2_ERR0       = 8'h00;
   localparam logic [7:0] PS2_ERR1       = 8'hFF;

   // Event word layout: {ext, brk, code[7:0]}
   localparam int EV_W = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_E0   = 2'd1,
      ST_F0   = 2'd2,
      ST_E0F0 = 2'd3
   } ps2_state_t;

   function automatic logic is_err_byte(input logic [7:0] b);
      return (b == PS2_ERR0) || (b == PS2_ERR1);
   endfunction

   function automatic logic [EV_W-1:0] pack_event(input logic ext, input logic brk,
                                                   input logic [7:0] code);
      return {ext, brk, code};
   endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Register-based event FIFO with async active-high reset, occupancy count and full/empty flags.
module ps2_event_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty = (level == '0);
   assign full  = (level == (AW+1)'(DEPTH));

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Head slot is never overwritten while occupied, so it stays stable until popped.
   assign head = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/ps2_key_sequencer.sv
// Folds E0/F0 scan-code prefixes into key events, queues them and drives the LED.
// Optional auto-repeat suppression is enabled with `define TYPEMATIC_FILTER_EN.
module ps2_key_sequencer
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic                         clock_fpga,
   input  logic                         reset,
   input  logic                         new_code,
   input  logic [7:0]                   code_in,
   output logic                         ev_valid,
   input  logic                         ev_ready,
   output logic [7:0]                   ev_code,
   output logic                         ev_ext,
   output logic                         ev_break,
   output logic [$clog2(FIFO_DEPTH):0]  ev_level,
   output logic                         overflow,
   output logic                         kbd_err,
   output logic                         led
);

   localparam int             TW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYC - 1);

   ps2_state_t      state;
   ps2_state_t      state_next;
   logic [TW-1:0]   tmo_cnt;
   logic            emit;
   logic            emit_ext;
   logic            emit_brk;
   logic            err_byte;
   logic            suppress;
   logic            push_q;
   logic [EV_W-1:0] ev_q;
   logic [EV_W-1:0] head;
   logic            fifo_full;
   logic            fifo_empty;
   logic            pop;
   logic            accepted;

   always_ff @(posedge clock_fpga or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Prefix bytes only move the state; any other byte closes the sequence.
   always_comb begin
      state_next = state;
      emit       = 1'b0;
      emit_ext   = 1'b0;
      emit_brk   = 1'b0;
      err_byte   = 1'b0;
      if (new_code) begin
         if (is_err_byte(code_in)) begin
            err_byte   = 1'b1;
            state_next = ST_IDLE;
         end else if (code_in == PS2_PREFIX_EXT) begin
            state_next = ST_E0;
         end else if (code_in == PS2_PREFIX_BRK) begin
            state_next = (state == ST_E0) ? ST_E0F0 : ST_F0;
         end else begin
            emit       = 1'b1;
            emit_ext   = (state == ST_E0) || (state == ST_E0F0);
            emit_brk   = (state == ST_F0) || (state == ST_E0F0);
            state_next = ST_IDLE;
         end
      end else if ((state != ST_IDLE) && (tmo_cnt == TMO_LAST)) begin
         state_next = ST_IDLE;
      end
   end

   always_ff @(posedge clock_fpga or posedge reset) begin
      if (reset) begin
         tmo_cnt <= '0;
      end else if (new_code || (state == ST_IDLE) || (tmo_cnt == TMO_LAST)) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

`ifdef TYPEMATIC_FILTER_EN
   logic       held;
   logic [8:0] held_key;
   logic [8:0] cur_key;

   assign cur_key  = {emit_ext, code_in};
   assign suppress = emit && !emit_brk && held && (cur_key == held_key);

   always_ff @(posedge clock_fpga or posedge reset) begin
      if (reset) begin
         held     <= 1'b0;
         held_key <= '0;
      end else if (emit && !emit_brk && !suppress) begin
         held     <= 1'b1;
         held_key <= cur_key;
      end else if (emit && emit_brk && held && (cur_key == held_key)) begin
         held <= 1'b0;
      end
   end
`else
   assign suppress = 1'b0;
`endif

   // Events are staged one cycle so the push lands in the cycle after new_code.
   always_ff @(posedge clock_fpga or posedge reset) begin
      if (reset) begin
         push_q  <= 1'b0;
         ev_q    <= '0;
         kbd_err <= 1'b0;
      end else begin
         push_q  <= emit && !suppress;
         ev_q    <= pack_event(emit_ext, emit_brk, code_in);
         kbd_err <= err_byte;
      end
   end

   // Handshake: the head transfers on any cycle where ev_valid && ev_ready;
   // while ev_valid is high and ev_ready low the ev_* fields hold steady.
   assign pop      = ev_valid && ev_ready;
   assign accepted = push_q && (!fifo_full || pop);

   ps2_event_fifo #(
      .WIDTH (EV_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clock_fpga),
      .rst       (reset),
      .push      (push_q),
      .push_data (ev_q),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (ev_level)
   );

   assign ev_valid = !fifo_empty;
   assign ev_ext   = head[9];
   assign ev_break = head[8];
   assign ev_code  = head[7:0];

   always_ff @(posedge clock_fpga or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
         led      <= 1'b0;
      end else begin
         if (push_q && fifo_full && !pop) begin
            overflow <= 1'b1;
         end
         if (accepted) begin
            led <= !ev_q[8];
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer: prefix folding, timeout, errors, FIFO limits, LED.
module tb_ps2_key_sequencer;

   localparam int DEPTH = 8;
   localparam int TMO   = 64;

   logic        clock_fpga;
   logic        reset;
   logic        new_code;
   logic [7:0]  code_in;
   logic        ev_valid;
   logic        ev_ready;
   logic [7:0]  ev_code;
   logic        ev_ext;
   logic        ev_break;
   logic [3:0]  ev_level;
   logic        overflow;
   logic        kbd_err;
   logic        led;

   int checks = 0;
   int errors = 0;
   logic [9:0] exp_q[$];

   ps2_key_sequencer #(
      .FIFO_DEPTH  (DEPTH),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clock_fpga (clock_fpga),
      .reset      (reset),
      .new_code   (new_code),
      .code_in    (code_in),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_code    (ev_code),
      .ev_ext     (ev_ext),
      .ev_break   (ev_break),
      .ev_level   (ev_level),
      .overflow   (overflow),
      .kbd_err    (kbd_err),
      .led        (led)
   );

   // clock / watchdog
   initial clock_fpga = 1'b0;
   always #5 clock_fpga = ~clock_fpga;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // scoreboard: every accepted head must match the next expected event
   always @(negedge clock_fpga) begin
      if (!reset && ev_valid && ev_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            assert (exp_q.size() != 0) else begin
               errors++;
               $error("FAIL spurious_event: observed %0h expected none", {ev_ext, ev_break, ev_code});
            end
         end else begin
            check("event", {22'd0, ev_ext, ev_break, ev_code}, {22'd0, exp_q.pop_front()});
         end
      end
   end

   // driver tasks
   task automatic send_byte(input logic [7:0] b);
      @(posedge clock_fpga); #1;
      new_code = 1'b1;
      code_in  = b;
      @(posedge clock_fpga); #1;
      new_code = 1'b0;
      repeat (4) @(posedge clock_fpga);
   endtask

   task automatic expect_ev(input logic ext, input logic brk, input logic [7:0] code);
      exp_q.push_back({ext, brk, code});
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || ev_level != 0) && n < 100) begin
         @(posedge clock_fpga);
         n++;
      end
      @(negedge clock_fpga);
      check({tag, "_drained"}, exp_q.size(), 0);
      check({tag, "_level0"}, {28'd0, ev_level}, 0);
   endtask

   task automatic do_reset;
      @(posedge clock_fpga); #1;
      reset = 1'b1;
      #3;
      check("rst_valid", {31'd0, ev_valid}, 0);
      check("rst_level", {28'd0, ev_level}, 0);
      check("rst_ovf",   {31'd0, overflow}, 0);
      check("rst_led",   {31'd0, led}, 0);
      check("rst_err",   {31'd0, kbd_err}, 0);
      check("rst_code",  {22'd0, ev_ext, ev_break, ev_code}, 0);
      @(posedge clock_fpga); #1;
      reset = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      reset    = 1'b1;
      new_code = 1'b0;
      code_in  = 8'h00;
      ev_ready = 1'b1;
      repeat (3) @(posedge clock_fpga);
      do_reset();

      // 1: single make, latency two cycles
      expect_ev(1'b0, 1'b0, 8'h75);
      @(posedge clock_fpga); #1;
      new_code = 1'b1;
      code_in  = 8'h75;
      @(posedge clock_fpga); #1;
      new_code = 1'b0;
      @(negedge clock_fpga);
      check("t1_valid_early", {31'd0, ev_valid}, 0);
      @(negedge clock_fpga);
      check("t1_valid", {31'd0, ev_valid}, 1);
      check("t1_led", {31'd0, led}, 1);
      @(negedge clock_fpga);
      check("t1_level", {28'd0, ev_level}, 0);
      wait_drain("t1");

      // 2: break
      send_byte(8'hF0);
      check("t2_no_prefix_ev", {28'd0, ev_level}, 0);
      expect_ev(1'b0, 1'b1, 8'h75);
      send_byte(8'h75);
      wait_drain("t2");
      check("t2_led", {31'd0, led}, 0);

      // 3: extended break, repeated E0
      expect_ev(1'b1, 1'b1, 8'h75);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      wait_drain("t3a");
      expect_ev(1'b1, 1'b0, 8'h1C);
      send_byte(8'hE0); send_byte(8'hE0); send_byte(8'h1C);
      wait_drain("t3b");
      check("t3_led", {31'd0, led}, 1);

      // 4: timeout, short gap, error byte, reset mid-prefix
      send_byte(8'hE0);
      repeat (TMO + 5) @(posedge clock_fpga);
      expect_ev(1'b0, 1'b0, 8'h1C);
      send_byte(8'h1C);
      wait_drain("t4_tmo");
      send_byte(8'hE0);
      repeat (10) @(posedge clock_fpga);
      expect_ev(1'b1, 1'b0, 8'h1C);
      send_byte(8'h1C);
      wait_drain("t4_short");
      @(posedge clock_fpga); #1;
      new_code = 1'b1;
      code_in  = 8'hFF;
      @(posedge clock_fpga); #1;
      new_code = 1'b0;
      @(negedge clock_fpga);
      check("t4_err_pulse", {31'd0, kbd_err}, 1);
      @(negedge clock_fpga);
      check("t4_err_clear", {31'd0, kbd_err}, 0);
      repeat (3) @(posedge clock_fpga);
      check("t4_err_noev", {28'd0, ev_level}, 0);
      send_byte(8'hE0); send_byte(8'hF0);
      do_reset();
      expect_ev(1'b0, 1'b0, 8'h75);
      send_byte(8'h75);
      wait_drain("t4_rst");

      // 5: overflow with consumer stalled
      ev_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i < 8) expect_ev(1'b0, 1'b0, 8'h10 + 8'(i));
         send_byte(8'h10 + 8'(i));
      end
      @(negedge clock_fpga);
      check("t5_level_full", {28'd0, ev_level}, 8);
      check("t5_overflow", {31'd0, overflow}, 1);
      check("t5_head_stable", {24'd0, ev_code}, 32'h10);
      ev_ready = 1'b1;
      wait_drain("t5");
      check("t5_ovf_sticky", {31'd0, overflow}, 1);

      // 5b: push and pop together while full
      do_reset();
      ev_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         expect_ev(1'b0, 1'b0, 8'h20 + 8'(i));
         send_byte(8'h20 + 8'(i));
      end
      expect_ev(1'b0, 1'b0, 8'h28);
      @(posedge clock_fpga); #1;
      new_code = 1'b1;
      code_in  = 8'h28;
      @(posedge clock_fpga); #1;
      new_code = 1'b0;
      ev_ready = 1'b1;
      @(posedge clock_fpga); #1;
      ev_ready = 1'b0;
      @(negedge clock_fpga);
      check("t5b_level", {28'd0, ev_level}, 8);
      check("t5b_no_ovf", {31'd0, overflow}, 0);
      ev_ready = 1'b1;
      wait_drain("t5b");

      // 6: auto-repeat
      expect_ev(1'b0, 1'b0, 8'h75);
`ifndef TYPEMATIC_FILTER_EN
      expect_ev(1'b0, 1'b0, 8'h75);
      expect_ev(1'b0, 1'b0, 8'h75);
`endif
      expect_ev(1'b0, 1'b1, 8'h75);
      send_byte(8'h75); send_byte(8'h75); send_byte(8'h75);
      send_byte(8'hF0); send_byte(8'h75);
      wait_drain("t6");
      check("t6_led", {31'd0, led}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
